// File: rtl/iir_pole.sv
// -----------------------------------------------------------------------------
// iir_pole -- recursive (pole) half of a biquad IIR filter.
//
// Computes y[n] = (x[n] - A1*y[n-1] - A2*y[n-2]) / 2^SHIFT with a single
// time-shared multiplier driven by a four-state FSM:
//   IDLE -> MAC1 -> MAC2 -> OUT -> IDLE
// One sample is accepted at most every 4 clocks. The result is rounded half up,
// saturated to DOUT_W bits, and the saturated value is fed back as history.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   clr        in   1       synchronous clear: flush history, drop in-flight sample
//   in_valid   in   1       Xin valid
//   in_ready   out  1       block accepts a sample this cycle (state == IDLE)
//   Xin        in   DIN_W   signed input sample x[n]
//   Xout       out  DOUT_W  signed output y[n], held until the next result
//   out_valid  out  1       one-cycle pulse, Xout updated
//   sat        out  1       one-cycle pulse with out_valid, result was clipped
// -----------------------------------------------------------------------------
module iir_pole #(
  parameter int        DIN_W  = 25,
  parameter int        DOUT_W = 12,
  parameter int        COE_W  = 12,
  parameter int        SHIFT  = 10,
  parameter int signed A1     = -1910,
  parameter int signed A2     = 888
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DIN_W-1:0]  Xin,
  output logic signed [DOUT_W-1:0] Xout,
  output logic                     out_valid,
  output logic                     sat
);

  // Two guard bits on top of the largest operand sum: the accumulator can
  // never wrap for any input and any saturated history.
  localparam int ACC_W  = DIN_W + COE_W + 2;
  localparam int PROD_W = COE_W + DOUT_W;
  localparam int R_W    = ACC_W - SHIFT;

  localparam logic signed [COE_W-1:0]  C_A1   = A1[COE_W-1:0];
  localparam logic signed [COE_W-1:0]  C_A2   = A2[COE_W-1:0];
  localparam logic signed [ACC_W-1:0]  C_HALF =
    {{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [DOUT_W-1:0] C_MAX  = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic signed [DOUT_W-1:0] C_MIN  = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC1 = 2'd1,
    S_MAC2 = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DOUT_W-1:0] r_y1;
  logic signed [DOUT_W-1:0] r_y2;
  logic signed [DOUT_W-1:0] r_xout;
  logic                     r_out_valid;
  logic                     r_sat;

  logic                     w_accept;
  logic signed [COE_W-1:0]  w_coef;
  logic signed [DOUT_W-1:0] w_hist;
  logic signed [PROD_W-1:0] w_coef_ext;
  logic signed [PROD_W-1:0] w_hist_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_xin_ext;
  logic signed [ACC_W-1:0]  w_acc_mac;
  logic signed [ACC_W-1:0]  w_acc_rnd;
  logic signed [R_W-1:0]    w_r;
  logic [R_W-DOUT_W:0]      w_r_hi;
  logic                     w_ovf;
  logic signed [DOUT_W-1:0] w_y_sat;

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state / handshake logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) begin
          w_state_next = S_MAC1;
        end
      end
      S_MAC1:  w_state_next = S_MAC2;
      S_MAC2:  w_state_next = S_OUT;
      S_OUT:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared multiplier: MAC2 uses (A2, y2), every other state presents (A1, y1).
  // Operands are widened to the full product width first, so the truncated
  // product is exact.
  // ---------------------------------------------------------------------------
  assign w_coef     = (r_state == S_MAC2) ? C_A2 : C_A1;
  assign w_hist     = (r_state == S_MAC2) ? r_y2 : r_y1;
  assign w_coef_ext = {{DOUT_W{w_coef[COE_W-1]}}, w_coef};
  assign w_hist_ext = {{COE_W{w_hist[DOUT_W-1]}}, w_hist};
  assign w_prod     = w_coef_ext * w_hist_ext;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_xin_ext  = {{(ACC_W-DIN_W){Xin[DIN_W-1]}}, Xin};
  assign w_acc_mac  = r_acc - w_prod_ext;

  // ---------------------------------------------------------------------------
  // Round half up, then arithmetic shift: dropping the low SHIFT bits of a
  // two's-complement value is a floor division.
  // ---------------------------------------------------------------------------
  assign w_acc_rnd = r_acc + C_HALF;
  assign w_r       = w_acc_rnd[ACC_W-1:SHIFT];

  // In range exactly when all bits from the output sign bit upward agree.
  assign w_r_hi  = w_r[R_W-1:DOUT_W-1];
  assign w_ovf   = !((&w_r_hi) || !(|w_r_hi));
  assign w_y_sat = w_ovf ? (w_r[R_W-1] ? C_MIN : C_MAX) : w_r[DOUT_W-1:0];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_xout      <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else if (clr) begin
      // Xout deliberately keeps its last value across a clear.
      r_acc       <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc <= w_xin_ext;
          end
        end
        S_MAC1, S_MAC2: begin
          r_acc <= w_acc_mac;
        end
        S_OUT: begin
          r_xout      <= w_y_sat;
          r_sat       <= w_ovf;
          r_out_valid <= 1'b1;
          // History holds the clipped value so the loop stays bounded.
          r_y2        <= r_y1;
          r_y1        <= w_y_sat;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign Xout      = r_xout;
  assign out_valid = r_out_valid;
  assign sat       = r_sat;

endmodule

// File: tb/tb_iir_pole.sv
// -----------------------------------------------------------------------------
// tb_iir_pole -- directed and random checks for iir_pole.
// A scoreboard models every accepted sample and checks each out_valid pulse
// (value, sat flag, latency); directed tests also compare hand-computed values.
// -----------------------------------------------------------------------------
module tb_iir_pole;

  localparam longint M_A1 = -1910;
  localparam longint M_A2 = 888;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [24:0] Xin = '0;
  logic signed [11:0] Xout;
  logic               out_valid;
  logic               sat;

  always #5 clk = ~clk;

  iir_pole dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xin       (Xin),
    .Xout      (Xout),
    .out_valid (out_valid),
    .sat       (sat)
  );

  int     n_total = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint m_y1 = 0;
  longint m_y2 = 0;
  longint exp_hold = 0;
  int     acc_cnt = 0;
  int     ov_cnt = 0;

  typedef struct {
    longint y;
    longint s;
    longint c;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Accept monitor + reference model, evaluated on the edge that accepts.
  always @(posedge clk) begin
    longint a, r, y;
    exp_t   e;
    cyc = cyc + 1;
    if (rst_n) begin
      if (clr) begin
        q.delete();
        m_y1 = 0;
        m_y2 = 0;
      end else if (in_valid && in_ready) begin
        a = longint'(Xin) - M_A1 * m_y1 - M_A2 * m_y2;
        r = (a + 512) >>> 10;
        y = (r > 2047) ? 2047 : ((r < -2048) ? -2048 : r);
        e.y = y;
        e.s = (r != y) ? 1 : 0;
        e.c = cyc;
        m_y2 = m_y1;
        m_y1 = y;
        q.push_back(e);
        acc_cnt++;
        $display("accept x=%0d exp_y=%0d exp_sat=%0d", Xin, e.y, e.s);
      end
    end
  end

  // Output checker, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid) begin
      ov_cnt++;
      if (q.size() == 0) begin
        chk("spurious_ov", longint'(out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("y", longint'(Xout), e.y);
        chk("sat", longint'(sat), e.s);
        chk("latency", cyc - e.c, 3);
        exp_hold = e.y;
      end
    end else if (sat) begin
      chk("sat_no_ov", longint'(sat), 0);
    end
  end

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    m_y1 = 0;
    m_y2 = 0;
    exp_hold = 0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Present one sample as soon as in_ready is seen; returns after it is taken.
  task automatic send_nb(input logic signed [24:0] x);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) chk("ready_timeout", longint'(in_ready), 1);
    in_valid = 1'b1;
    Xin      = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic signed [24:0] x, output longint y, output longint s);
    int k;
    send_nb(x);
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ov_seen", longint'(out_valid), 1);
    chk("send_lat", longint'(k), 3);
    y = longint'(Xout);
    s = longint'(sat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint y, s;
    int     a0, ov0, x;

    // 1: reset
    do_reset(3);
    chk("rst_xout", longint'(Xout), 0);
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_ready", longint'(in_ready), 1);
    ov0 = ov_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_ov", longint'(ov_cnt - ov0), 0);

    // 2: impulse
    send(25'sd1024, y, s); chk("imp0", y, 1); chk("imp0_sat", s, 0);
    send(25'sd0, y, s);    chk("imp1", y, 2); chk("imp1_sat", s, 0);
    send(25'sd0, y, s);    chk("imp2", y, 3); chk("imp2_sat", s, 0);

    // 3: saturation
    do_clr();
    send(25'sd16777215, y, s);  chk("sat_pos", y, 2047);  chk("sat_pos_f", s, 1);
    do_clr();
    send(-25'sd16777216, y, s); chk("sat_neg", y, -2048); chk("sat_neg_f", s, 1);

    // 4: continuous in_valid, changing data every clock
    do_clr();
    a0 = acc_cnt;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      Xin      = 25'(i * 37111 - 700000);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("hs_count", longint'(acc_cnt - a0), 10);
    repeat (6) @(posedge clk);
    #1;

    // 5a: clr during MAC2 drops the sample
    ov0 = ov_cnt;
    in_valid = 1'b1;
    Xin      = 25'sd1024;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_clr_ov", longint'(ov_cnt - ov0), 0);
    chk("abort_clr_xout", longint'(Xout), exp_hold);
    send(25'sd1024, y, s); chk("after_clr", y, 1);

    // 5b: reset pulse during MAC1
    in_valid = 1'b1;
    Xin      = 25'sd1024;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ov0 = ov_cnt;
    rst_n = 1'b0;
    q.delete();
    m_y1 = 0;
    m_y2 = 0;
    exp_hold = 0;
    #1;
    chk("abort_rst_xout", longint'(Xout), 0);
    chk("abort_rst_ov", longint'(out_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_rst_no_ov", longint'(ov_cnt - ov0), 0);
    chk("abort_rst_hold", longint'(Xout), 0);
    chk("abort_rst_ready", longint'(in_ready), 1);
    send(25'sd1024, y, s); chk("after_rst", y, 1);

    // 6: random stream with gaps
    for (int k = 0; k < 2000; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      x = int'($urandom_range(0, 2097151)) - 1048576;
      send_nb(25'(x));
    end
    repeat (8) @(posedge clk);
    #1;
    chk("queue_drained", longint'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
